draw_image: RTL and testbench
=============================

DRAW_IMAGE -- requirements
Module: draw_image

Interface
REQ-001 The block SHALL have these parameters:
- IMG_WIDTH, 48, image width in pixels (at most 64).
- IMG_HEIGHT, 64, image height in pixels (at most 64).
- TRANSPARENT_KEY, 12'hF0F, colour-key value; used only under DRAW_IMAGE_TRANSPARENT_EN.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- xpos  in  12  image left edge; sampled at frame start.
- ypos  in  12  image top edge; sampled at frame start.
- hcount_in, vcount_in  in  11 each  incoming pixel coordinates.
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  incoming timing.
- rgb_in  in  12  background colour.
- rom_addr  out  12  image ROM address {y[5:0], x[5:0]}, registered.
- rom_rgb  in  12  ROM data; valid one clk after rom_addr.
- hcount_out, vcount_out  out  11 each  delayed coordinates.
- hsync_out, hblnk_out, vsync_out, vblnk_out  out  1 each  delayed timing.
- rgb_out  out  12  composited colour.

Function
REQ-003 Frame start SHALL be the cycle with hcount_in==0 and vcount_in==0; on it the block SHALL latch xpos/ypos into xpos_l/ypos_l and set pos_valid=1.
REQ-004 xpos_l/ypos_l SHALL hold for the whole frame; xpos/ypos changes mid-frame SHALL NOT move the image until the next frame start.
REQ-005 Stage 1 (edge k) SHALL compute inside = pos_valid & !hblnk_in & !vblnk_in & (hcount_in - xpos_l) in [0, IMG_WIDTH) & (vcount_in - ypos_l) in [0, IMG_HEIGHT).
REQ-006 Comparisons SHALL use 13-bit signed differences, so xpos_l/ypos_l values beyond the screen or near 4095 never wrap into a false hit; the image SHALL clip at screen edges.
REQ-007 At edge k, rom_addr SHALL be set to {ry[5:0], rx[5:0]} (rx/ry = relative offsets) when inside, else 12'h000.
REQ-008 All timing, count and rgb_in signals SHALL pass through a 2-stage delay line; each output at edge k+2 SHALL equal its input sampled at edge k, with exactly 2 cycles latency in every case.
REQ-009 At edge k+2, rgb_out SHALL be rom_rgb if the delayed inside flag is 1, else the delayed rgb_in.
REQ-010 When hblnk_in or vblnk_in is 1, rgb_out SHALL equal the delayed rgb_in; the image is never drawn in blanking.
REQ-011 If frame start and an in-window pixel coincide (xpos=ypos=0), the newly sampled xpos/ypos SHALL apply to that same pixel.

Reset
REQ-012 While rst=1 at an edge: every output, rom_addr, every delay stage, xpos_l, ypos_l and pos_valid SHALL become 0.
REQ-013 After reset is released mid-frame, no image pixel SHALL be drawn until the next frame start sets pos_valid.
REQ-014 The first valid outputs after reset SHALL appear 2 cycles after the first sampled input.

Configuration
REQ-015 With DRAW_IMAGE_TRANSPARENT_EN defined, an inside pixel whose rom_rgb == TRANSPARENT_KEY SHALL output the delayed rgb_in.
REQ-016 With DRAW_IMAGE_TRANSPARENT_EN undefined, rom_rgb SHALL be output unconditionally inside the window, and TRANSPARENT_KEY SHALL have no effect.

Verification
REQ-017 The bench SHALL cover these scenarios:
- xpos=100, ypos=50; pixel (hcount=110, vcount=60) -> rom_addr=12'h28A one cycle later; rgb_out=ROM word 0x28A two cycles after input.
- Pixel (147,113) inside; pixels (148,50) and (99,50) outside -> rgb_out = rgb_in for the outside pixels, delayed by 2 cycles.
- xpos changed 100->300 at vcount=200 -> rest of frame still drawn at x=100; next frame drawn at x=300.
- xpos=4090 -> no pixel drawn anywhere, no wrap at hcount 0..5; xpos=780 -> only columns 780..799 drawn.
- rst=1 at vcount=300 for 3 cycles -> all outputs 0; no image drawn until the next frame start.
- TRANSPARENT_EN defined, ROM word 12'hF0F at an inside pixel, rgb_in=12'h123 -> rgb_out=12'h123; undefined -> 12'hF0F.

Source files
------------

// File: rtl/draw_image.sv
// draw_image -- composites a ROM-held image over an incoming video stream.
//
// Pipeline (edge k = edge that samples the input pixel):
//   edge k   : window test, ROM address issued, stage-1 delay capture
//   edge k+1 : stage-2 delay capture, external ROM returns the word
//   edge k+2 : registered outputs, rgb_out = ROM word or background
//
// The image position is latched at frame start (hcount_in==0, vcount_in==0)
// and holds for the whole frame.
//
// Optional feature: define DRAW_IMAGE_TRANSPARENT_EN to treat ROM words equal
// to TRANSPARENT_KEY as see-through (background shows instead).

module draw_image #(
   parameter int          IMG_WIDTH       = 48,
   parameter int          IMG_HEIGHT      = 64,
   parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [11:0] rom_addr,
   input  logic [11:0] rom_rgb,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   // Everything that only needs to be delayed, bundled so the delay line
   // stays one assignment per stage.
   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        hblnk;
      logic        vsync;
      logic        vblnk;
      logic [11:0] rgb;
   } video_t;

   localparam logic signed [12:0] IMG_W_S = 13'(IMG_WIDTH);
   localparam logic signed [12:0] IMG_H_S = 13'(IMG_HEIGHT);

   // Latched image position for the current frame
   logic [11:0] xpos_l;
   logic [11:0] ypos_l;
   logic        pos_valid;

   // Delay line and inside flags
   video_t      video_in;
   video_t      stage1;
   video_t      stage2;
   logic        inside1;
   logic        inside2;

   // Stage-1 combinational window test
   logic               frame_start;
   logic [11:0]        xpos_cur;
   logic [11:0]        ypos_cur;
   logic               valid_cur;
   logic signed [12:0] dx;
   logic signed [12:0] dy;
   logic               in_x;
   logic               in_y;
   logic               inside_cur;
   logic               use_rom;

   assign video_in = '{hcount: hcount_in, vcount: vcount_in,
                       hsync: hsync_in, hblnk: hblnk_in,
                       vsync: vsync_in, vblnk: vblnk_in,
                       rgb: rgb_in};

   // On the frame-start pixel the freshly sampled position applies at once,
   // so an image placed at (0,0) draws its first pixel correctly.
   assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
   assign xpos_cur    = frame_start ? xpos : xpos_l;
   assign ypos_cur    = frame_start ? ypos : ypos_l;
   assign valid_cur   = frame_start | pos_valid;

   // 13-bit signed offsets: positions near 4095 give a negative offset
   // instead of wrapping onto the left/top of the screen.
   assign dx = $signed({2'b00, hcount_in}) - $signed({1'b0, xpos_cur});
   assign dy = $signed({2'b00, vcount_in}) - $signed({1'b0, ypos_cur});

   assign in_x = !dx[12] && (dx < IMG_W_S);
   assign in_y = !dy[12] && (dy < IMG_H_S);

   assign inside_cur = valid_cur & ~hblnk_in & ~vblnk_in & in_x & in_y;

`ifdef DRAW_IMAGE_TRANSPARENT_EN
   assign use_rom = inside2 && (rom_rgb != TRANSPARENT_KEY);
`else
   logic unused_key;
   assign unused_key = ^TRANSPARENT_KEY;
   assign use_rom    = inside2;
`endif

   // Latch the image position at frame start; hold it for the frame
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block order.
      if (rst) begin
         xpos_l    <= 12'd0;
         ypos_l    <= 12'd0;
         pos_valid <= 1'b0;
      end else if (frame_start) begin
         xpos_l    <= xpos;
         ypos_l    <= ypos;
         pos_valid <= 1'b1;
      end
   end

   // Stage 1: capture video, issue ROM address for in-window pixels
   always_ff @(posedge clk) begin
      if (rst) begin
         stage1   <= '0;
         inside1  <= 1'b0;
         rom_addr <= 12'd0;
      end else begin
         stage1   <= video_in;
         inside1  <= inside_cur;
         rom_addr <= inside_cur ? {dy[5:0], dx[5:0]} : 12'd0;
      end
   end

   // Stage 2: second delay slot while the ROM fetches the word
   always_ff @(posedge clk) begin
      if (rst) begin
         stage2  <= '0;
         inside2 <= 1'b0;
      end else begin
         stage2  <= stage1;
         inside2 <= inside1;
      end
   end

   // Output register: delayed timing plus composited colour
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_out <= 11'd0;
         vcount_out <= 11'd0;
         hsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vsync_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= 12'd0;
      end else begin
         hcount_out <= stage2.hcount;
         vcount_out <= stage2.vcount;
         hsync_out  <= stage2.hsync;
         hblnk_out  <= stage2.hblnk;
         vsync_out  <= stage2.vsync;
         vblnk_out  <= stage2.vblnk;
         rgb_out    <= use_rom ? rom_rgb : stage2.rgb;
      end
   end

endmodule

// File: tb/tb_draw_image.sv
// tb_draw_image -- directed + randomized bench for draw_image.
// A behavioural model works out, per driven pixel, the expected ROM address
// and the expected output two edges later from the image-window rules.

module tb_draw_image;

   localparam int          IMG_W = 48;
   localparam int          IMG_H = 64;
   localparam logic [11:0] KEY   = 12'hF0F;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
   logic [11:0] rgb_in;
   logic [11:0] rom_addr;
   logic [11:0] rom_rgb;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
   logic [11:0] rgb_out;

   always #5 clk = ~clk;

   draw_image #(
      .IMG_WIDTH      (IMG_W),
      .IMG_HEIGHT     (IMG_H),
      .TRANSPARENT_KEY(KEY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .xpos      (xpos),
      .ypos      (ypos),
      .hcount_in (hcount_in),
      .vcount_in (vcount_in),
      .hsync_in  (hsync_in),
      .hblnk_in  (hblnk_in),
      .vsync_in  (vsync_in),
      .vblnk_in  (vblnk_in),
      .rgb_in    (rgb_in),
      .rom_addr  (rom_addr),
      .rom_rgb   (rom_rgb),
      .hcount_out(hcount_out),
      .vcount_out(vcount_out),
      .hsync_out (hsync_out),
      .hblnk_out (hblnk_out),
      .vsync_out (vsync_out),
      .vblnk_out (vblnk_out),
      .rgb_out   (rgb_out)
   );

   // Image ROM: synchronous read, word valid one clock after the address
   logic [11:0] rom_mem [4096];
   always @(posedge clk) rom_rgb <= rom_mem[rom_addr];

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic [3:0]  sync;   // {hsync, hblnk, vsync, vblnk}
      logic [11:0] rgb;
      logic [11:0] addr;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Model state: position in force for the current frame
   int   mdl_x  = 0;
   int   mdl_y  = 0;
   bit   mdl_pv = 1'b0;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One pixel: check what the DUT shows now, then drive the next pixel and
   // record what it should produce.
   task automatic step(input int h, input int v, input bit hb, input bit vb,
                       input logic [11:0] rgb, input bit r);
      exp_t e;
      bit   hs, vs, ins;
      int   rx, ry;
      @(negedge clk);
      if (q.size() >= 1)
         check("rom_addr", 32'(rom_addr), 32'(q[q.size()-1].addr));
      if (q.size() >= 3) begin
         e = q[q.size()-3];
         check("hcount_out", 32'(hcount_out), 32'(e.h));
         check("vcount_out", 32'(vcount_out), 32'(e.v));
         check("sync_out", 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}),
               32'(e.sync));
         check("rgb_out", 32'(rgb_out), 32'(e.rgb));
      end
      hs        = 1'($urandom_range(0, 1));
      vs        = 1'($urandom_range(0, 1));
      rst       = r;
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hsync_in  = hs;
      vsync_in  = vs;
      hblnk_in  = hb;
      vblnk_in  = vb;
      rgb_in    = rgb;
      if (r) begin
         // Reset clears the whole pipeline: the two pixels still in flight
         // come out as zero, as does this one.
         mdl_x  = 0;
         mdl_y  = 0;
         mdl_pv = 1'b0;
         if (q.size() >= 1) q[q.size()-1] = '0;
         if (q.size() >= 2) q[q.size()-2] = '0;
         q.push_back('0);
      end else begin
         if (h == 0 && v == 0) begin
            mdl_x  = int'(xpos);
            mdl_y  = int'(ypos);
            mdl_pv = 1'b1;
         end
         rx  = h - mdl_x;
         ry  = v - mdl_y;
         ins = mdl_pv && !hb && !vb && rx >= 0 && rx < IMG_W && ry >= 0 && ry < IMG_H;
         e.h    = 11'(h);
         e.v    = 11'(v);
         e.sync = {hs, hb, vs, vb};
         e.addr = ins ? 12'(ry * 64 + rx) : 12'd0;
         e.rgb  = rgb;
         if (ins) begin
            e.rgb = rom_mem[e.addr];
`ifdef DRAW_IMAGE_TRANSPARENT_EN
            if (rom_mem[e.addr] == KEY) e.rgb = rgb;
`endif
         end
         q.push_back(e);
      end
      if (q.size() > 8) void'(q.pop_front());
   endtask

   task automatic pix(input int h, input int v);
      step(h, v, 1'b0, 1'b0, 12'($urandom), 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(700, 400, 1'b1, 1'b1, 12'($urandom), 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         rom_mem[i] = 12'($urandom);
         if (rom_mem[i] == KEY) rom_mem[i] = 12'h001;
      end
      rom_mem[12'h085] = KEY;      // transparent word at image offset (5,2)

      rst = 1'b1; xpos = 12'd100; ypos = 12'd50;
      hcount_in = '0; vcount_in = '0; rgb_in = '0;
      hsync_in = 0; hblnk_in = 0; vsync_in = 0; vblnk_in = 0;

      // Reset, then pixels before any frame start: nothing drawn
      for (int i = 0; i < 4; i++) step(110, 60, 1'b0, 1'b0, 12'($urandom), 1'b1);
      pix(110, 60);
      pix(120, 70);

      // Frame at (100,50): reference pixel, inside corner, outside neighbours
      pix(0, 0);
      pix(110, 60);                // rom_addr 12'h28A
      pix(147, 113);
      pix(148, 50);
      pix(99, 50);
      for (int i = 0; i < 300; i++)
         step($urandom_range(80, 170), $urandom_range(40, 120),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
              12'($urandom), 1'b0);

      // Mid-frame position change must wait for the next frame start
      xpos = 12'd300;
      pix(120, 200);
      pix(120, 60);
      pix(310, 60);
      for (int i = 0; i < 50; i++) pix($urandom_range(80, 360), $urandom_range(40, 120));
      pix(0, 0);
      pix(310, 60);
      pix(120, 60);
      step(305, 52, 1'b0, 1'b0, 12'h123, 1'b0);   // transparent ROM word
      for (int i = 0; i < 100; i++) pix($urandom_range(280, 360), $urandom_range(40, 120));

      // Position near 4095: no wrap onto the left edge
      xpos = 12'd4090; ypos = 12'd0;
      pix(0, 0);
      for (int v = 0; v < 4; v++)
         for (int h = 0; h < 6; h++) if (h != 0 || v != 0) pix(h, v);
      for (int i = 0; i < 60; i++) pix($urandom_range(1, 60), $urandom_range(0, 70));

      // Right-edge clipping: only columns 780..799 drawn
      xpos = 12'd780; ypos = 12'd0;
      pix(0, 0);
      for (int v = 5; v <= 10; v += 5)
         for (int h = 770; h <= 810; h++)
            step(h, v, (h >= 800), 1'b0, 12'($urandom), 1'b0);

      // Reset mid-frame: image stays off until the next frame start
      xpos = 12'd100; ypos = 12'd50;
      pix(0, 0);
      pix(110, 60);
      pix(111, 60);
      for (int i = 0; i < 3; i++) step(120 + i, 300, 1'b0, 1'b0, 12'($urandom), 1'b1);
      pix(110, 60);
      pix(130, 90);
      idle(2);
      pix(0, 0);
      pix(110, 60);
      pix(130, 90);

      // Frame start coinciding with an in-window pixel at (0,0)
      xpos = 12'd0; ypos = 12'd0;
      pix(0, 0);
      pix(5, 5);
      pix(47, 63);
      pix(48, 63);

      idle(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
